// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
//   tx_state_t : transmitter FSM states
//   PAR_*      : PARITY_MODE encodings
//   baud_div   : clk cycles per bit, rounded to nearest
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int baud_div(input int clkFreq, input int baud);
    return (clkFreq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   restart : begin a fresh bit period (full DIV cycles until the next tick)
//   enable  : count while high
//   tick    : one-cycle pulse on the last cycle of every DIV-cycle period
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Down-counter: terminal count is zero, then reload the full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (restart) begin
      cnt <= RELOAD;
    end else if (enable) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
    end
  end

  assign tick = enable && !restart && (cnt == '0);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter. Accepts a word of WORD_BYTES characters
// over valid/ready and sends it as back-to-back frames, LSB character first.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   tx_valid : word offered
//   tx_data  : word, char k = tx_data[k*DATA_BITS +: DATA_BITS]
//   tx_ready : idle, a word will be accepted this cycle
//   tx_busy  : ~tx_ready
//   tx_done  : one-cycle pulse when the last stop bit of the word ends
//   txd      : serial line, idle high
//
// state  | meaning
// IDLE   | line high, waiting for tx_valid
// START  | start bit (0)
// DATA   | DATA_BITS data bits, LSB first
// PARITY | parity bit (parity build only)
// STOP   | STOP_BITS stop bits (1); then next char or IDLE
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 25000000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int WORD_BYTES  = 2,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tx_valid,
  input  logic [WORD_BYTES*DATA_BITS-1:0] tx_data,
  output logic                            tx_ready,
  output logic                            tx_busy,
  output logic                            tx_done,
  output logic                            txd
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || WORD_BYTES < 1 || WORD_BYTES > 4 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD))
  begin : gBadParam
    $error("uart_tx_param: parameter out of range");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [1:0] LAST_CHAR = 2'(WORD_BYTES - 1);

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = (PARITY_MODE != PAR_NONE);
  logic parBit;
`endif

  tx_state_t state;
  // One spare character of padding so the "next char" select is always in range.
  logic [(WORD_BYTES+1)*DATA_BITS-1:0] wordReg;
  logic [DATA_BITS-1:0]                shiftReg;
  logic [3:0]                          bitCnt;
  logic [1:0]                          charIdx;
  logic                                accept;
  logic                                tick;

  assign accept  = tx_ready && tx_valid;
  assign tx_busy = ~tx_ready;

  uart_baud_tick #(.DIV(DIV)) uBaud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .enable  (state != IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
      wordReg  <= '0;
      shiftReg <= '0;
      bitCnt   <= '0;
      charIdx  <= '0;
`ifdef UART_TX_PARITY_EN
      parBit   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (tx_valid) begin
            wordReg  <= {{DATA_BITS{1'b0}}, tx_data};
            shiftReg <= tx_data[DATA_BITS-1:0];
            charIdx  <= '0;
            bitCnt   <= '0;
            state    <= START;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state  <= DATA;
            txd    <= shiftReg[0];
            bitCnt <= '0;
`ifdef UART_TX_PARITY_EN
            // Parity of the whole character, taken before it shifts out.
            parBit <= (PARITY_MODE == PAR_ODD) ? ~^shiftReg : ^shiftReg;
`endif
          end
        end
        DATA: begin
          if (tick) begin
            if (bitCnt == LAST_DATA) begin
              bitCnt <= '0;
`ifdef UART_TX_PARITY_EN
              if (PAR_ON) begin
                state <= PARITY;
                txd   <= parBit;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              shiftReg <= shiftReg >> 1;
              txd      <= shiftReg[1];
              bitCnt   <= bitCnt + 4'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state  <= STOP;
            txd    <= 1'b1;
            bitCnt <= '0;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bitCnt == LAST_STOP) begin
              bitCnt <= '0;
              if (charIdx == LAST_CHAR) begin
                state    <= IDLE;
                tx_done  <= 1'b1;
                tx_ready <= 1'b1;
              end else begin
                // Next character starts with no gap.
                charIdx  <= charIdx + 2'd1;
                wordReg  <= wordReg >> DATA_BITS;
                shiftReg <= wordReg[DATA_BITS +: DATA_BITS];
                state    <= START;
                txd      <= 1'b0;
              end
            end else begin
              bitCnt <= bitCnt + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
